// File: rtl/debouncer_bank_if.sv
// Bus bundle between a debouncer bank and its consumer (GPIO event / UART report logic).
// rise_o/fall_o/change_o are single-cycle pulses with no back-pressure: a consumer must sample them every clock.
interface debouncer_bank_if #(
  parameter int CHANNELS = 8
);
  logic [CHANNELS-1:0] signal_i;
  logic [CHANNELS-1:0] signal_o;
  logic [CHANNELS-1:0] rise_o;
  logic [CHANNELS-1:0] fall_o;
  logic                change_o;
  logic [CHANNELS-1:0] confirm_o;  // debug view: bit k set while channel k is in CONFIRM

  modport master (
    output signal_i,
    input  signal_o, rise_o, fall_o, change_o, confirm_o
  );

  modport slave (
    input  signal_i,
    output signal_o, rise_o, fall_o, change_o, confirm_o
  );
endinterface

// File: rtl/debouncer_bank.sv
// Multi-channel debouncer: per-channel synchroniser, STABLE/CONFIRM filter with a period counter,
// and registered one-cycle rise/fall pulses plus an aggregate change pulse.
module debouncer_bank #(
  parameter int                  CHANNELS    = 8,
  parameter int                  CLOCK_FREQ  = 100000000,
  parameter int                  DEBOUNCE_HZ = 1000,
  parameter int                  SYNC_STAGES = 2,
  parameter logic [CHANNELS-1:0] INIT_VALUE  = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  debouncer_bank_if.slave bus
);

  localparam int            LIM     = CLOCK_FREQ / DEBOUNCE_HZ;
  localparam int            CW      = (LIM > 2) ? $clog2(LIM) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(LIM - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  if (LIM < 2) begin : g_bad_lim
    $fatal(1, "debouncer_bank: CLOCK_FREQ/DEBOUNCE_HZ must be at least 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $fatal(1, "debouncer_bank: SYNC_STAGES must be at least 2");
  end

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_CONFIRM = 1'b1
  } state_e;

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] s;

  state_e              state_q [CHANNELS];
  state_e              state_d [CHANNELS];
  logic [CW-1:0]       cnt_q   [CHANNELS];
  logic [CW-1:0]       cnt_d   [CHANNELS];

  logic [CHANNELS-1:0] qual;
  logic [CHANNELS-1:0] sig_q, sig_d;
  logic [CHANNELS-1:0] rise_q, rise_d;
  logic [CHANNELS-1:0] fall_q, fall_d;
  logic                change_q, change_d;
  logic [CHANNELS-1:0] confirm;

  // Synchroniser chain; the last stage is the only version of the input the filter ever sees.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= INIT_VALUE;
      end
    end else begin
      sync_q[0] <= bus.signal_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CHANNELS; k++) begin
        state_q[k] <= ST_STABLE;
        cnt_q[k]   <= '0;
      end
      sig_q    <= INIT_VALUE;
      rise_q   <= '0;
      fall_q   <= '0;
      change_q <= 1'b0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
      sig_q    <= sig_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      change_q <= change_d;
    end
  end

  // A single matching cycle drops back to STABLE, so the count always restarts from zero.
  always_comb begin
    qual = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];
      unique case (state_q[k])
        ST_STABLE: begin
          if (s[k] != sig_q[k]) begin
            state_d[k] = ST_CONFIRM;
            cnt_d[k]   = CNT_ONE;
          end else begin
            cnt_d[k]   = '0;
          end
        end
        ST_CONFIRM: begin
          if (s[k] == sig_q[k]) begin
            state_d[k] = ST_STABLE;
            cnt_d[k]   = '0;
          end else if (cnt_q[k] == CNT_MAX) begin
            state_d[k] = ST_STABLE;
            cnt_d[k]   = '0;
            qual[k]    = 1'b1;
          end else begin
            cnt_d[k]   = cnt_q[k] + CNT_ONE;
          end
        end
        default: begin
          state_d[k] = ST_STABLE;
          cnt_d[k]   = '0;
        end
      endcase
    end
  end

  // Qualifying channels take the synchronised value; pulses are registered alongside the level.
  always_comb begin
    sig_d    = sig_q ^ qual;
    rise_d   = qual & s;
    fall_d   = qual & ~s;
    change_d = |qual;
  end

  always_comb begin
    confirm = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      confirm[k] = (state_q[k] == ST_CONFIRM);
    end
  end

  assign bus.signal_o  = sig_q;
  assign bus.rise_o    = rise_q;
  assign bus.fall_o    = fall_q;
  assign bus.change_o  = change_q;
  assign bus.confirm_o = confirm;

endmodule

// File: tb/tb_debouncer_bank.sv
// Bench for debouncer_bank: vector table, hand-written corner sequences and a random phase,
// all cross-checked every cycle against a sliding-window reference model.
module tb_debouncer_bank;

  localparam int         CH   = 8;
  localparam int         LIM  = 10;
  localparam int         SYNC = 2;
  localparam logic [7:0] INIT = 8'h0F;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  debouncer_bank_if #(.CHANNELS(CH)) bus ();

  debouncer_bank #(
    .CHANNELS    (CH),
    .CLOCK_FREQ  (1000),
    .DEBOUNCE_HZ (100),
    .SYNC_STAGES (SYNC),
    .INIT_VALUE  (INIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic check_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pk(input logic [7:0] o, input logic [7:0] r,
                                     input logic [7:0] f, input logic c);
    return {7'b0, o, r, f, c};
  endfunction

  function automatic logic [31:0] dut_out();
    return pk(bus.signal_o, bus.rise_o, bus.fall_o, bus.change_o);
  endfunction

  // Reference model: a level flips when the last LIM synchronised samples all disagree with it.
  logic [7:0] m_pipe [$];
  logic [7:0] m_win  [$];
  logic [7:0] m_lvl, m_rise, m_fall;
  logic       m_chg;

  task automatic model_reset();
    m_pipe.delete();
    for (int i = 0; i < SYNC; i++) m_pipe.push_back(INIT);
    m_win.delete();
    m_lvl  = INIT;
    m_rise = '0;
    m_fall = '0;
    m_chg  = 1'b0;
  endtask

  task automatic model_step();
    logic [7:0] s;
    logic [7:0] m;
    s = m_pipe.pop_front();
    m_pipe.push_back(bus.signal_i);
    m_win.push_back(s);
    if (m_win.size() > LIM) void'(m_win.pop_front());
    m = '0;
    if (m_win.size() == LIM) begin
      m = '1;
      foreach (m_win[i]) m &= (m_win[i] ^ m_lvl);
    end
    m_lvl  = m_lvl ^ m;
    m_rise = m & m_lvl;
    m_fall = m & ~m_lvl;
    m_chg  = |m;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // scoreboard against the model, sampled mid-cycle
  always @(negedge clk) begin
    if (check_en) check("model", dut_out(), pk(m_lvl, m_rise, m_fall, m_chg));
  end

  typedef struct {
    string      name;
    logic [7:0] din;
    int         wait_n;
    logic [7:0] exp_o;
    logic [7:0] exp_rise;
    logic [7:0] exp_fall;
    logic       exp_chg;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [7:0] cur;
    logic [7:0] mask;
    int         hold;

    vecs[0] = '{"ch4_wait",   8'h1F, 11, 8'h0F, 8'h00, 8'h00, 1'b0};
    vecs[1] = '{"ch4_rise",   8'h1F,  1, 8'h1F, 8'h10, 8'h00, 1'b1};
    vecs[2] = '{"ch4_after",  8'h1F,  1, 8'h1F, 8'h00, 8'h00, 1'b0};
    vecs[3] = '{"ch4_held",   8'h1F, 20, 8'h1F, 8'h00, 8'h00, 1'b0};
    vecs[4] = '{"simul_wait", 8'h5E, 11, 8'h1F, 8'h00, 8'h00, 1'b0};
    vecs[5] = '{"simul_edge", 8'h5E,  1, 8'h5E, 8'h40, 8'h01, 1'b1};
    vecs[6] = '{"simul_once", 8'h5E,  1, 8'h5E, 8'h00, 8'h00, 1'b0};
    vecs[7] = '{"simul_held", 8'h5E, 30, 8'h5E, 8'h00, 8'h00, 1'b0};

    // reset value
    bus.signal_i = 8'hF0;
    #1 rst_n = 1'b0;
    #2;
    check("reset_state", dut_out(), pk(8'h0F, 8'h00, 8'h00, 1'b0));
    repeat (3) @(negedge clk);
    bus.signal_i = 8'h0F;
    check_en = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    repeat (50) begin
      @(negedge clk);
      check("release_quiet", dut_out(), pk(8'h0F, 8'h00, 8'h00, 1'b0));
    end

    // vector table: drive at a negedge, check after wait_n rising edges
    for (int i = 0; i < 8; i++) begin
      bus.signal_i = vecs[i].din;
      repeat (vecs[i].wait_n) @(negedge clk);
      check(vecs[i].name, dut_out(),
            pk(vecs[i].exp_o, vecs[i].exp_rise, vecs[i].exp_fall, vecs[i].exp_chg));
    end

    // glitch on ch5: nine synchronised high cycles never qualify
    bus.signal_i = 8'h7E;
    repeat (9) begin
      @(negedge clk);
      check("glitch_high", dut_out(), pk(8'h5E, 8'h00, 8'h00, 1'b0));
    end
    bus.signal_i = 8'h5E;
    repeat (16) begin
      @(negedge clk);
      check("glitch_after", dut_out(), pk(8'h5E, 8'h00, 8'h00, 1'b0));
    end
    bus.signal_i = 8'h7E;
    repeat (11) @(negedge clk);
    check("ch5_pre", 32'(bus.signal_o), 32'(8'h5E));
    @(negedge clk);
    check("ch5_rise", dut_out(), pk(8'h7E, 8'h20, 8'h00, 1'b1));

    // reset in the middle of a ch7 confirm
    bus.signal_i = 8'hFE;
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("rst_mid", dut_out(), pk(8'h0F, 8'h00, 8'h00, 1'b0));
    repeat (3) begin
      @(negedge clk);
      check("rst_hold_ch7", 32'(bus.signal_o[7]), 32'(1'b0));
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    repeat (11) @(negedge clk);
    check("rst_rel_pre", 32'(bus.signal_o[7]), 32'(1'b0));
    @(negedge clk);
    check("rst_rel_edge", dut_out(), pk(8'hFE, 8'hF0, 8'h01, 1'b1));

    // bounce train on ch1 (3 low / 2 high) then held low
    for (int p = 0; p < 8; p++) begin
      bus.signal_i = 8'hFC;
      repeat (3) begin
        @(negedge clk);
        check("bounce_lo", 32'(bus.signal_o[1]), 32'(1'b1));
      end
      bus.signal_i = 8'hFE;
      repeat (2) begin
        @(negedge clk);
        check("bounce_hi", 32'(bus.signal_o[1]), 32'(1'b1));
      end
    end
    bus.signal_i = 8'hFC;
    repeat (11) begin
      @(negedge clk);
      check("ch1_hold", 32'(bus.signal_o[1]), 32'(1'b1));
    end
    @(negedge clk);
    check("ch1_fall", dut_out(), pk(8'hFC, 8'h00, 8'h02, 1'b1));
    @(negedge clk);
    check("ch1_once", dut_out(), pk(8'hFC, 8'h00, 8'h00, 1'b0));

    // random phase, checked only by the model
    cur = 8'hFC;
    for (int seg = 0; seg < 250; seg++) begin
      mask = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
      cur  = cur ^ mask;
      hold = $urandom_range(1, 16);
      bus.signal_i = cur;
      repeat (hold) @(negedge clk);
      if (seg % 60 == 30) begin
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
      end
    end
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
